// File: rtl/secded_decoder_pkg.sv
// Shared types and constants for the SECDED decoder: FSM states, status codes,
// parity-bit positions and the data-extraction helper.
package secded_decoder_pkg;

    typedef enum logic [2:0] {
        ST_HI     = 3'd0,
        ST_LO     = 3'd1,
        ST_DEC    = 3'd2,
        ST_OUT_HI = 3'd3,
        ST_OUT_LO = 3'd4
    } dec_state_t;

    localparam logic [1:0] kSTAT_CLEAN = 2'b00;
    localparam logic [1:0] kSTAT_SEC   = 2'b01;
    localparam logic [1:0] kSTAT_DED   = 2'b10;

    localparam int kPOS_P16 = 0;
    localparam int kPOS_P1  = 1;
    localparam int kPOS_P2  = 2;
    localparam int kPOS_P4  = 4;
    localparam int kPOS_P8  = 8;

    // Data bits b11..b1 live at every non-power-of-two position above 0.
    function automatic logic [10:0] extract_data(input logic [15:0] w);
        return {w[15:9], w[7:5], w[3]};
    endfunction

endpackage

// File: rtl/secded_decoder_if.sv
// Byte-stream input and output handshakes of the SECDED decoder.
interface secded_decoder_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic [1:0] status;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_byte, out_last, status
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_byte, out_last, status
    );

endinterface

// File: rtl/secded_decoder_syndrome.sv
// Combinational SECDED check: syndrome, overall parity, single-bit correction
// and classification of a 16-bit encoded word.
module secded_syndrome
    import secded_decoder_pkg::*;
(
    input  logic [15:0] word,
    output logic [3:0]  syndrome,
    output logic        parity,
    output logic [10:0] data,
    output logic [1:0]  status
);

    logic [15:0] fixed;

    // Odd overall parity means one flipped bit; a zero syndrome then points at p16 itself.
    always_comb begin
        syndrome = '0;
        for (int i = 1; i < 16; i++) begin
            if (word[i]) syndrome = syndrome ^ 4'(i);
        end
        parity = ^word;
        fixed  = word;
        status = kSTAT_CLEAN;
        if (parity) begin
            status = kSTAT_SEC;
            if (syndrome != 4'd0) fixed[syndrome] = ~word[syndrome];
        end else if (syndrome != 4'd0) begin
            status = kSTAT_DED;
        end
        data = extract_data(fixed);
    end

endmodule

// File: rtl/secded_decoder.sv
// SECDED decoder top: two-beat capture, one decode cycle, two-beat output
// with held status, plus saturating single/double error counters.
module secded_decoder
    import secded_decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    secded_decoder_if.slave  bus,
    output logic             busy,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] sec_count,
    output logic [CNT_W-1:0] ded_count
);

    dec_state_t  state;
    logic [7:0]  word_hi;
    logic [7:0]  word_lo;
    logic [7:0]  lo_r;
    logic [3:0]  dec_syndrome;
    logic        dec_parity;
    logic [10:0] dec_data;
    logic [1:0]  dec_status;

    secded_syndrome u_syndrome (
        .word     ({word_hi, word_lo}),
        .syndrome (dec_syndrome),
        .parity   (dec_parity),
        .data     (dec_data),
        .status   (dec_status)
    );

    // Handshake outputs are registered alongside the state so they change only with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_HI;
            word_hi       <= '0;
            word_lo       <= '0;
            lo_r          <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_byte  <= '0;
            bus.status    <= kSTAT_CLEAN;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_HI: begin
                    if (bus.in_valid) begin
                        word_hi <= bus.in_byte;
                        busy    <= 1'b1;
                        state   <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (bus.in_valid) begin
                        word_lo      <= bus.in_byte;
                        bus.in_ready <= 1'b0;
                        state        <= ST_DEC;
                    end
                end
                ST_DEC: begin
                    lo_r          <= dec_data[7:0];
                    bus.status    <= dec_status;
                    bus.out_byte  <= {5'b0, dec_data[10:8]};
                    bus.out_valid <= 1'b1;
                    bus.out_last  <= 1'b0;
                    state         <= ST_OUT_HI;
                end
                ST_OUT_HI: begin
                    if (bus.out_ready) begin
                        bus.out_byte <= lo_r;
                        bus.out_last <= 1'b1;
                        state        <= ST_OUT_LO;
                    end
                end
                ST_OUT_LO: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= ST_HI;
                    end
                end
                default: begin
                    state         <= ST_HI;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

    // Clear beats a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (clr_counts) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (state == ST_DEC) begin
            if (dec_parity && (sec_count != '1))
                sec_count <= sec_count + CNT_W'(1);
            if (!dec_parity && (dec_syndrome != 4'd0) && (ded_count != '1))
                ded_count <= ded_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_secded_decoder.sv
// Directed bench for secded_decoder: expected beats are queued when a word is
// sent and popped when the decoder emits it; counters follow a saturating model.
module tb_secded_decoder;

    localparam int CNT_W = 2;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [1:0] st;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             busy;
    logic             clr_counts;
    logic [CNT_W-1:0] sec_count;
    logic [CNT_W-1:0] ded_count;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   expSec = 0;
    int   expDed = 0;

    secded_decoder_if bus ();

    secded_decoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .busy       (busy),
        .clr_counts (clr_counts),
        .sec_count  (sec_count),
        .ded_count  (ded_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, "_sec"}, 32'(sec_count), 32'(expSec));
        checkOutput({tag, "_ded"}, 32'(ded_count), 32'(expDed));
    endtask

    // Drives MSW then LSW; returns at the negedge while the decoder sits in its decode cycle.
    task automatic applyStimulus(input logic [7:0] hi, input logic [7:0] lo,
                                 input logic [7:0] eHi, input logic [7:0] eLo, input logic [1:0] eSt);
        exp_t e;
        e.hi = eHi; e.lo = eLo; e.st = eSt;
        expQ.push_back(e);
        @(negedge clk);
        checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_byte  = hi;
        @(negedge clk);
        bus.in_byte  = lo;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("in_ready_dec", 32'(bus.in_ready), 32'd0);
        checkOutput("busy_dec", 32'(busy), 32'd1);
    endtask

    task automatic receiveWord(input int hold, input bit clrInDec);
        exp_t e;
        int   cycles = 0;
        if (expQ.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: observed=0 expected=1");
            errors++;
            checks++;
            return;
        end
        e = expQ.pop_front();
        bus.out_ready = (hold == 0);
        if (clrInDec) clr_counts = 1'b1;
        while (!bus.out_valid && cycles < 20) begin
            @(negedge clk);
            clr_counts = 1'b0;
            cycles++;
        end
        checkOutput("out_valid_seen", 32'(bus.out_valid), 32'd1);
        checkOutput("latency", 32'(cycles), 32'd1);
        checkOutput("beat_hi", 32'(bus.out_byte), 32'(e.hi));
        checkOutput("last_hi", 32'(bus.out_last), 32'd0);
        checkOutput("status_hi", 32'(bus.status), 32'(e.st));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("bp_byte", 32'(bus.out_byte), 32'(e.hi));
            checkOutput("bp_status", 32'(bus.status), 32'(e.st));
            checkOutput("bp_last", 32'(bus.out_last), 32'd0);
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("beat_lo", 32'(bus.out_byte), 32'(e.lo));
        checkOutput("last_lo", 32'(bus.out_last), 32'd1);
        checkOutput("status_lo", 32'(bus.status), 32'(e.st));
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("out_valid_done", 32'(bus.out_valid), 32'd0);
        checkOutput("in_ready_done", 32'(bus.in_ready), 32'd1);
        checkOutput("busy_done", 32'(busy), 32'd0);
    endtask

    function automatic void bumpSec();
        if (expSec < (1 << CNT_W) - 1) expSec++;
    endfunction

    initial begin
        rst_n         = 1'b0;
        clr_counts    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_byte   = '0;
        bus.out_ready = 1'b0;
        #12;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_byte", 32'(bus.out_byte), 32'd0);
        checkOutput("rst_status", 32'(bus.status), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkCounts("rst");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] clean word");
        applyStimulus(8'h00, 8'h0F, 8'h00, 8'h01, 2'b00);
        receiveWord(0, 1'b0);
        checkCounts("clean");

        $display("[TB] single data-bit error");
        applyStimulus(8'h00, 8'h2F, 8'h00, 8'h01, 2'b01);
        receiveWord(0, 1'b0);
        bumpSec();
        checkCounts("sec");

        $display("[TB] p16-only error");
        applyStimulus(8'h00, 8'h0E, 8'h00, 8'h01, 2'b01);
        receiveWord(0, 1'b0);
        bumpSec();
        checkCounts("p16");

        $display("[TB] double error");
        applyStimulus(8'h02, 8'h2F, 8'h00, 8'h13, 2'b10);
        receiveWord(0, 1'b0);
        expDed++;
        checkCounts("ded");

        $display("[TB] backpressure on double error");
        applyStimulus(8'h02, 8'h2F, 8'h00, 8'h13, 2'b10);
        receiveWord(3, 1'b0);
        expDed++;
        checkCounts("bp");

        $display("[TB] reset after MSW");
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h02;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        expSec = 0;
        expDed = 0;
        checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkCounts("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h00, 8'h2F, 8'h00, 8'h01, 2'b01);
        receiveWord(0, 1'b0);
        bumpSec();
        checkCounts("post_rst");

        $display("[TB] saturation");
        for (int n = 0; n < 4; n++) begin
            applyStimulus(8'h00, 8'h0E, 8'h00, 8'h01, 2'b01);
            receiveWord(0, 1'b0);
            bumpSec();
            checkCounts("sat");
        end

        $display("[TB] clear during decode");
        applyStimulus(8'h00, 8'h2F, 8'h00, 8'h01, 2'b01);
        receiveWord(0, 1'b1);
        expSec = 0;
        expDed = 0;
        checkCounts("clr_sat");
        applyStimulus(8'h00, 8'h2F, 8'h00, 8'h01, 2'b01);
        receiveWord(0, 1'b1);
        checkCounts("clr_prio");
        applyStimulus(8'h00, 8'h2F, 8'h00, 8'h01, 2'b01);
        receiveWord(0, 1'b0);
        bumpSec();
        checkCounts("after_clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
